// File: rtl/management_rx_fifo.sv
// management_rx_fifo
//   Store-and-forward receive FIFO between a MAC-style byte stream and a
//   word-oriented management reader. Bytes of a frame are written speculatively
//   into a circular byte buffer; a good frame is committed by pushing its length
//   into a small header FIFO, a bad or aborted frame is rolled back and counted.
//   The reader sees the head frame length, fetches 16-bit words from it, and
//   pops the frame when done.
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   rx_bus_start              start of a new frame (discards any partial frame)
//   rx_bus_data_valid/data    one frame byte per cycle
//   rx_bus_commit/drop        end of frame, good / bad (both together = bad)
//   rd_frame_valid/len        a committed frame is queued, and its byte length
//   rd_en                     fetch the next 16-bit word of the head frame
//   rd_busy                   fetch in flight, rd_en and rd_pop ignored
//   rd_data/rd_data_valid     fetched word (first byte in [7:0]) and its strobe
//   rd_pop                    drop the rest of the head frame and dequeue it
//   drop_count                saturating count of discarded frames
module management_rx_fifo #(
   parameter int unsigned DEPTH     = 4096,
   parameter int unsigned HDR_DEPTH = 32,
   parameter int unsigned MAX_LEN   = 1536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_bus_start,
   input  logic        rx_bus_data_valid,
   input  logic [7:0]  rx_bus_data,
   input  logic        rx_bus_commit,
   input  logic        rx_bus_drop,
   output logic        rd_frame_valid,
   output logic [10:0] rd_frame_len,
   input  logic        rd_en,
   output logic        rd_busy,
   output logic [15:0] rd_data,
   output logic        rd_data_valid,
   input  logic        rd_pop,
   output logic [15:0] drop_count
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned PW  = AW + 1;
   localparam int unsigned HAW = $clog2(HDR_DEPTH);
   localparam int unsigned HPW = HAW + 1;

   // Fetch sequencer: byte 0 is read from RAM in the accept cycle, byte 1 in
   // StByte0, and the assembled word is registered out of StByte1.
   typedef enum logic [1:0] {
      StIdle,
      StByte0,
      StByte1
   } rd_state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  commit_ptr_q, commit_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [10:0]    len_q, len_d;
   logic           bad_q, bad_d;
   logic [15:0]    drop_count_q, drop_count_d;
   logic [HPW-1:0] hdr_wr_q, hdr_wr_d;
   logic [HPW-1:0] hdr_rd_q, hdr_rd_d;
   logic [10:0]    rd_off_q, rd_off_d;
   rd_state_e      state_q, state_d;
   logic [1:0]     nbytes_q, nbytes_d;
   logic [AW-1:0]  addr1_q, addr1_d;
   logic [7:0]     lo_q, lo_d;
   logic [15:0]    rd_data_q, rd_data_d;
   logic           rd_data_valid_q, rd_data_valid_d;

   logic [10:0]    hdr_mem [HDR_DEPTH];
   logic [7:0]     buf_mem [DEPTH];
   logic [7:0]     ram_rdata_q;

   // ---------------------------------------------------------------------------
   // Derived status
   // ---------------------------------------------------------------------------
   logic [PW-1:0]  used;
   logic           has_space;
   logic [HPW-1:0] hdr_cnt;
   logic           hdr_full;
   logic           hdr_empty;
   logic           len_ok;
   logic           commit_ok;
   logic           end_drop;
   logic           buf_we;
   logic           hdr_push;
   logic [10:0]    head_len;
   logic [10:0]    rem;
   logic           off_past_end;
   logic           rd_accept;
   logic           pop_accept;
   logic [AW-1:0]  rd_base;
   logic [AW-1:0]  raddr;

   // Occupancy includes the uncommitted bytes of the frame being received.
   assign used      = wr_ptr_q - rd_ptr_q;
   assign has_space = (used != PW'(DEPTH));
   assign hdr_cnt   = hdr_wr_q - hdr_rd_q;
   assign hdr_full  = (hdr_cnt == HPW'(HDR_DEPTH));
   assign hdr_empty = (hdr_cnt == '0);
   assign len_ok    = (len_q < 11'(MAX_LEN));

   // Commit together with drop is a drop.
   assign commit_ok = rx_bus_commit & ~rx_bus_drop & ~bad_q & ~hdr_full & (len_q != '0);
   assign end_drop  = rx_bus_drop | (rx_bus_commit & ~commit_ok);

   assign head_len     = hdr_empty ? 11'd0 : hdr_mem[hdr_rd_q[HAW-1:0]];
   assign rem          = head_len - rd_off_q;
   assign off_past_end = (rd_off_q >= head_len);
   assign rd_accept    = rd_en & ~hdr_empty & (state_q == StIdle);
   // rd_en wins over rd_pop in the same cycle.
   assign pop_accept   = rd_pop & ~rd_en & ~hdr_empty & (state_q == StIdle);
   assign rd_base      = rd_ptr_q[AW-1:0] + AW'(rd_off_q);

   // ---------------------------------------------------------------------------
   // Write side
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      len_d        = len_q;
      bad_d        = bad_q;
      drop_count_d = drop_count_q;
      hdr_wr_d     = hdr_wr_q;
      buf_we       = 1'b0;
      hdr_push     = 1'b0;

      if (rx_bus_start) begin
         // Roll back any partial frame silently.
         wr_ptr_d = commit_ptr_q;
         len_d    = '0;
         bad_d    = 1'b0;
      end else if (commit_ok) begin
         hdr_push     = 1'b1;
         hdr_wr_d     = hdr_wr_q + 1'b1;
         commit_ptr_d = wr_ptr_q;
      end else if (end_drop) begin
         wr_ptr_d = commit_ptr_q;
         if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
         end
      end else if (rx_bus_data_valid) begin
         if (has_space && len_ok && !bad_q) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            len_d    = len_q + 11'd1;
         end else begin
            // Once a byte is lost the frame can only be dropped.
            bad_d = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read side
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d         = state_q;
      rd_off_d        = rd_off_q;
      nbytes_d        = nbytes_q;
      addr1_d         = addr1_q;
      lo_d            = lo_q;
      rd_data_d       = rd_data_q;
      rd_data_valid_d = 1'b0;
      rd_ptr_d        = rd_ptr_q;
      hdr_rd_d        = hdr_rd_q;
      raddr           = rd_base;

      case (state_q)
         StIdle: begin
            if (rd_accept) begin
               state_d = StByte0;
               addr1_d = rd_base + 1'b1;
               if (off_past_end) begin
                  nbytes_d = 2'd0;
               end else if (rem == 11'd1) begin
                  nbytes_d = 2'd1;
                  rd_off_d = rd_off_q + 11'd1;
               end else begin
                  nbytes_d = 2'd2;
                  rd_off_d = rd_off_q + 11'd2;
               end
            end else if (pop_accept) begin
               rd_ptr_d = rd_ptr_q + PW'(head_len);
               hdr_rd_d = hdr_rd_q + 1'b1;
               rd_off_d = '0;
            end
         end
         StByte0: begin
            raddr   = addr1_q;
            lo_d    = ram_rdata_q;
            state_d = StByte1;
         end
         StByte1: begin
            state_d         = StIdle;
            rd_data_valid_d = 1'b1;
            unique case (nbytes_q)
               2'd1:    rd_data_d = {8'h00, lo_q};
               2'd2:    rd_data_d = {ram_rdata_q, lo_q};
               default: rd_data_d = 16'h0000;
            endcase
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q        <= '0;
         commit_ptr_q    <= '0;
         rd_ptr_q        <= '0;
         len_q           <= '0;
         bad_q           <= 1'b0;
         drop_count_q    <= '0;
         hdr_wr_q        <= '0;
         hdr_rd_q        <= '0;
         rd_off_q        <= '0;
         state_q         <= StIdle;
         nbytes_q        <= '0;
         addr1_q         <= '0;
         lo_q            <= '0;
         rd_data_q       <= '0;
         rd_data_valid_q <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         commit_ptr_q    <= commit_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         len_q           <= len_d;
         bad_q           <= bad_d;
         drop_count_q    <= drop_count_d;
         hdr_wr_q        <= hdr_wr_d;
         hdr_rd_q        <= hdr_rd_d;
         rd_off_q        <= rd_off_d;
         state_q         <= state_d;
         nbytes_q        <= nbytes_d;
         addr1_q         <= addr1_d;
         lo_q            <= lo_d;
         rd_data_q       <= rd_data_d;
         rd_data_valid_q <= rd_data_valid_d;
      end
   end

   // Header storage; entries are only meaningful between hdr_rd and hdr_wr.
   always_ff @(posedge clk) begin
      if (hdr_push) begin
         hdr_mem[hdr_wr_q[HAW-1:0]] <= len_q;
      end
   end

   // Simple dual-port byte RAM, registered read, contents not reset.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_mem[wr_ptr_q[AW-1:0]] <= rx_bus_data;
      end
      ram_rdata_q <= buf_mem[raddr];
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign rd_frame_valid = ~hdr_empty;
   assign rd_frame_len   = head_len;
   assign rd_busy        = (state_q != StIdle);
   assign rd_data        = rd_data_q;
   assign rd_data_valid  = rd_data_valid_q;
   assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_management_rx_fifo.sv
// Bench for management_rx_fifo: directed scenarios plus a randomized mix of
// frames, word fetches and pops, checked against a queue-based frame model.
module tb_management_rx_fifo;

   localparam int DEPTH     = 64;
   localparam int HDR_DEPTH = 32;
   localparam int MAX_LEN   = 62;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_bus_start = 1'b0;
   logic        rx_bus_data_valid = 1'b0;
   logic [7:0]  rx_bus_data = 8'h00;
   logic        rx_bus_commit = 1'b0;
   logic        rx_bus_drop = 1'b0;
   logic        rd_frame_valid;
   logic [10:0] rd_frame_len;
   logic        rd_en = 1'b0;
   logic        rd_busy;
   logic [15:0] rd_data;
   logic        rd_data_valid;
   logic        rd_pop = 1'b0;
   logic [15:0] drop_count;

   always #5 clk = ~clk;

   management_rx_fifo #(
      .DEPTH     (DEPTH),
      .HDR_DEPTH (HDR_DEPTH),
      .MAX_LEN   (MAX_LEN)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .rx_bus_start      (rx_bus_start),
      .rx_bus_data_valid (rx_bus_data_valid),
      .rx_bus_data       (rx_bus_data),
      .rx_bus_commit     (rx_bus_commit),
      .rx_bus_drop       (rx_bus_drop),
      .rd_frame_valid    (rd_frame_valid),
      .rd_frame_len      (rd_frame_len),
      .rd_en             (rd_en),
      .rd_busy           (rd_busy),
      .rd_data           (rd_data),
      .rd_data_valid     (rd_data_valid),
      .rd_pop            (rd_pop),
      .drop_count        (drop_count)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: committed bytes in arrival order, per-frame lengths,
   // read offset into the head frame, and the discard count.
   logic [7:0] m_bytes[$];
   int         m_lens[$];
   int         m_off   = 0;
   int         m_drops = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_bytes.delete();
      m_lens.delete();
      m_off   = 0;
      m_drops = 0;
   endtask

   task automatic check_hdr(input string tag);
      check_eq({tag, "_valid"}, 32'(rd_frame_valid), 32'(m_lens.size() > 0));
      check_eq({tag, "_len"}, 32'(rd_frame_len), (m_lens.size() > 0) ? m_lens[0] : 0);
      check_eq({tag, "_drops"}, 32'(drop_count), m_drops);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_fvalid"}, 32'(rd_frame_valid), 0);
      check_eq({tag, "_flen"}, 32'(rd_frame_len), 0);
      check_eq({tag, "_busy"}, 32'(rd_busy), 0);
      check_eq({tag, "_data"}, 32'(rd_data), 0);
      check_eq({tag, "_dvalid"}, 32'(rd_data_valid), 0);
      check_eq({tag, "_drops"}, 32'(drop_count), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_bus_start = 1'b0;
      rx_bus_data_valid = 1'b0;
      rx_bus_commit = 1'b0;
      rx_bus_drop = 1'b0;
      rd_en = 1'b0;
      rd_pop = 1'b0;
      step();
      model_clear();
      check_reset_outputs("rst");
      rst = 1'b0;
   endtask

   // kind: 0 commit, 1 drop, 2 commit and drop together
   task automatic send_bytes(input logic [7:0] fb[$], input int kind, input bit gaps);
      int n;
      bit ok;
      n = fb.size();
      rx_bus_start = 1'b1;
      step();
      rx_bus_start = 1'b0;
      foreach (fb[i]) begin
         if (gaps) repeat ($urandom_range(0, 1)) step();
         rx_bus_data_valid = 1'b1;
         rx_bus_data = fb[i];
         step();
         rx_bus_data_valid = 1'b0;
      end
      rx_bus_commit = (kind != 1);
      rx_bus_drop = (kind != 0);
      step();
      rx_bus_commit = 1'b0;
      rx_bus_drop = 1'b0;
      ok = (kind == 0) && (n > 0) && (n <= MAX_LEN) && (n <= DEPTH - m_bytes.size())
           && (m_lens.size() < HDR_DEPTH);
      if (ok) begin
         foreach (fb[i]) m_bytes.push_back(fb[i]);
         m_lens.push_back(n);
      end else if (m_drops < 65535) begin
         m_drops++;
      end
      check_hdr("frame");
   endtask

   task automatic send_rand(input int n, input int kind, input bit gaps);
      logic [7:0] fb[$];
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
      send_bytes(fb, kind, gaps);
   endtask

   task automatic read_word(input bit with_pop, output logic [15:0] got_o);
      bit          has;
      int          pulses;
      int          lat;
      int          len;
      logic        busy1;
      logic        busy_at_valid;
      logic [15:0] got;
      logic [15:0] exp;
      has = (m_lens.size() > 0);
      pulses = 0;
      lat = 0;
      got = '0;
      busy_at_valid = 1'b0;
      rd_en = 1'b1;
      rd_pop = with_pop;
      step();
      rd_en = 1'b0;
      // A pop while busy must be ignored.
      rd_pop = 1'($urandom_range(0, 1));
      busy1 = rd_busy;
      for (int k = 1; k <= 6; k++) begin
         if (k == 2) rd_pop = 1'b0;
         if (rd_data_valid) begin
            pulses++;
            if (lat == 0) begin
               lat = k;
               got = rd_data;
               busy_at_valid = rd_busy;
            end
         end
         if (k < 6) step();
      end
      got_o = got;
      if (has) begin
         len = m_lens[0];
         if (m_off >= len) begin
            exp = 16'h0000;
         end else begin
            exp[7:0]  = m_bytes[m_off];
            exp[15:8] = (m_off + 1 < len) ? m_bytes[m_off + 1] : 8'h00;
            m_off += (len - m_off >= 2) ? 2 : 1;
         end
         check_eq("rd_busy", 32'(busy1), 1);
         check_eq("rd_latency", lat, 3);
         check_eq("rd_pulses", pulses, 1);
         check_eq("rd_busy_at_valid", 32'(busy_at_valid), 0);
         check_eq("rd_data", 32'(got), 32'(exp));
      end else begin
         check_eq("rd_empty_pulses", pulses, 0);
      end
      check_hdr("read");
   endtask

   task automatic pop_frame();
      logic [7:0] tmp;
      rd_pop = 1'b1;
      step();
      rd_pop = 1'b0;
      if (m_lens.size() > 0) begin
         for (int i = 0; i < m_lens[0]; i++) tmp = m_bytes.pop_front();
         void'(m_lens.pop_front());
         m_off = 0;
      end
      check_hdr("pop");
   endtask

   task automatic read_frame();
      logic [15:0] w;
      int nw;
      if (m_lens.size() > 0) begin
         nw = (m_lens[0] - m_off + 1) / 2;
         for (int i = 0; i < nw; i++) read_word(1'b0, w);
      end
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic [7:0]  fb[$];
      logic [15:0] w;
      int          pulses;

      do_reset();

      // Five-byte frame, odd tail, read past end.
      fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      send_bytes(fb, 0, 1'b0);
      check_eq("t5_len", 32'(rd_frame_len), 5);
      read_word(1'b0, w);
      check_eq("t5_w0", 32'(w), 32'h2211);
      read_word(1'b1, w);
      check_eq("t5_w1", 32'(w), 32'h4433);
      read_word(1'b0, w);
      check_eq("t5_w2", 32'(w), 32'h0055);
      read_word(1'b0, w);
      check_eq("t5_w3", 32'(w), 32'h0000);
      pop_frame();

      // Fetch and pop with nothing queued.
      read_word(1'b0, w);
      pop_frame();

      // Dropped frame, then a good 60-byte frame.
      send_rand(20, 1, 1'b1);
      check_eq("drop_cnt1", 32'(drop_count), 1);
      send_rand(60, 0, 1'b1);
      read_frame();
      pop_frame();

      // Oversize frame is discarded; exactly MAX_LEN and a 1-byte frame follow.
      send_rand(MAX_LEN + 1, 0, 1'b0);
      send_rand(1, 0, 1'b0);
      read_frame();
      pop_frame();
      send_rand(MAX_LEN, 0, 1'b0);
      read_frame();
      pop_frame();
      send_rand(3, 2, 1'b0);

      // Buffer full: second frame dropped, space reusable after pop, wraps.
      send_rand(40, 0, 1'b0);
      send_rand(30, 0, 1'b0);
      read_word(1'b0, w);
      pop_frame();
      send_rand(30, 0, 1'b1);
      read_frame();
      pop_frame();

      // Header FIFO full: 33rd one-byte frame dropped.
      do_reset();
      for (int i = 0; i < 33; i++) send_rand(1, 0, 1'b0);
      check_eq("hdr_full_drops", 32'(drop_count), 1);
      for (int i = 0; i < 32; i++) begin
         read_frame();
         pop_frame();
      end

      // Reset one cycle into a fetch.
      send_rand(4, 0, 1'b0);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      rst = 1'b1;
      step();
      model_clear();
      check_reset_outputs("rst_fetch");
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (rd_data_valid) pulses++;
      end
      check_eq("rst_fetch_no_valid", pulses, 0);

      // Randomized mix.
      for (int it = 0; it < 250; it++) begin
         int op;
         int r;
         op = int'($urandom_range(0, 5));
         case (op)
            0, 1: begin
               r = int'($urandom_range(0, 9));
               send_rand(int'($urandom_range(0, 70)), (r == 0) ? 1 : ((r == 1) ? 2 : 0),
                         1'($urandom_range(0, 1)));
            end
            2, 3: read_word(1'($urandom_range(0, 1)), w);
            4: pop_frame();
            default: begin
               read_frame();
               pop_frame();
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/management_rx_fifo.md
MANAGEMENT_RX_FIFO -- requirements
Module: management_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning data buffer size in bytes (power of 2).
REQ-002 SHALL have parameter HDR_DEPTH, default 32, meaning max committed frames queued (power of 2).
REQ-003 SHALL have parameter MAX_LEN, default 1536, meaning largest accepted frame in bytes (at most 2047).
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous, active-high.
- rx_bus_start  in  1  new frame begins; no data this cycle.
- rx_bus_data_valid  in  1  rx_bus_data carries one byte.
- rx_bus_data  in  8  frame byte.
- rx_bus_commit  in  1  end of frame, FCS good.
- rx_bus_drop  in  1  end of frame, FCS bad or aborted.
- rd_frame_valid  out  1  at least one committed frame queued.
- rd_frame_len  out  11  byte length of head frame (0 when none).
- rd_en  in  1  request next 16-bit word of head frame.
- rd_busy  out  1  word fetch in progress; rd_en ignored.
- rd_data  out  16  fetched word, first byte in [7:0].
- rd_data_valid  out  1  one-cycle strobe, rd_data valid.
- rd_pop  in  1  discard remainder of head frame and dequeue it.
- drop_count  out  16  saturating count of frames discarded by this block.

Function
REQ-005 SHALL keep wr_ptr, commit_ptr, rd_ptr, each log2(DEPTH)+1 bits wide; free space = DEPTH - (wr_ptr - rd_ptr), modulo 2^(log2(DEPTH)+1).
REQ-006 SHALL on rx_bus_start set wr_ptr to commit_ptr, clear frame length and frame-bad flag; any uncommitted partial frame is discarded without counting.
REQ-007 SHALL on rx_bus_data_valid write the byte at wr_ptr, then increment wr_ptr and length, only if free space > 0, length < MAX_LEN and frame-bad is clear.
REQ-008 SHALL otherwise set frame-bad; no write; wr_ptr unchanged.
REQ-009 SHALL on rx_bus_commit with frame-bad clear, header FIFO not full and length > 0, push length into header FIFO and set commit_ptr to wr_ptr the next cycle.
REQ-010 SHALL on rx_bus_commit with any of those conditions failed, or on rx_bus_drop, set wr_ptr to commit_ptr and increment drop_count (saturate at 16'hFFFF).
REQ-011 SHALL treat rx_bus_commit and rx_bus_drop asserted together as drop.
REQ-012 SHALL assert rd_frame_valid iff header FIFO not empty; rd_frame_len = head entry.
REQ-013 SHALL keep per-frame read offset rd_off (11 bits), zeroed on dequeue.
REQ-014 SHALL handle rd_en accepted (rd_frame_valid=1, rd_busy=0) as follows:
- rd_busy goes high the next cycle.
- Memory reads bytes at rd_ptr+rd_off and rd_ptr+rd_off+1.
- rd_data_valid pulses exactly 3 cycles after rd_en, with rd_busy low in that same cycle.
- rd_off advances by min(2, len-rd_off).
REQ-015 SHALL return 16'h0000 with rd_data_valid and not advance rd_off when rd_off >= len.
REQ-016 SHALL return upper byte 8'h00 when only one byte remains.
REQ-017 SHALL ignore rd_en when rd_frame_valid=0; no rd_data_valid.
REQ-018 SHALL on rd_pop with rd_frame_valid=1 and rd_busy=0 set rd_ptr to rd_ptr+len, pop header, clear rd_off; the next frame becomes visible at the earliest the following cycle.
REQ-019 SHALL ignore rd_pop when rd_busy=1 or rd_frame_valid=0.
REQ-020 SHALL give rd_en priority when rd_en and rd_pop are asserted together; rd_pop is ignored.
REQ-021 SHALL allow simultaneous write and read/pop every cycle; freed space usable the cycle after rd_pop.
REQ-022 SHALL handle pointer wrap-around transparently; frames may straddle buffer end.
REQ-023 SHALL infer buffer as simple dual-port block RAM, 8-bit wide, 1-cycle read latency.

Reset
REQ-024 SHALL on rst=1 at a clk edge, zero all pointers, rd_off, length, frame-bad, header FIFO, drop_count; outputs rd_frame_valid=0, rd_frame_len=0, rd_busy=0, rd_data=0, rd_data_valid=0.
REQ-025 SHALL on rst mid-frame or mid-fetch abandon all content; no rd_data_valid after reset release until a new rd_en.
REQ-026 SHALL leave buffer RAM contents uninitialised by reset.

Verification
REQ-027 SHALL cover 5-byte frame 11 22 33 44 55 committed -> rd_frame_len=5; three rd_en give 16'h2211, 16'h4433, 16'h0055, each 3 cycles after its rd_en; fourth rd_en gives 16'h0000.
REQ-028 SHALL cover frame with rx_bus_drop -> rd_frame_valid stays 0, drop_count=1; next 60-byte good frame is readable intact.
REQ-029 SHALL cover MAX_LEN+1 bytes then commit -> frame discarded, drop_count+1, wr_ptr equals commit_ptr.
REQ-030 SHALL cover DEPTH=64 with frames of 40 and 30 bytes -> second dropped; after rd_pop of first, a 30-byte frame fits and reads back correctly across wrap.
REQ-031 SHALL cover 33 back-to-back 1-byte frames, HDR_DEPTH=32 -> 33rd dropped, drop_count=1, 32 frames read in order.
REQ-032 SHALL cover rst asserted during fetch (cycle 1 after rd_en) -> no rd_data_valid; all outputs at reset values next cycle.
